// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Holds the system PLL in reset for a fixed time, waits for lock, and requires lock to stay
//   stable for a programmable time before releasing the core reset. A lock timeout triggers a
//   new PLL reset attempt. After too many failed attempts the block latches a fault until a
//   retry request arrives. A lock loss while running restarts the sequence and is counted.
//
// Ports
//   refclk        in   reference clock, sole clock domain
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock indicator, asynchronous, synchronized internally
//   retry         in   single-cycle request to leave FAULT
//   pll_rst       out  PLL reset, active high
//   core_reset    out  downstream reset, active high, low only in RUN
//   ready         out  high only in RUN
//   fault         out  high only in FAULT
//   relock_count  out  saturating count of lock losses seen in RUN
//   state         out  encoded state (RESET_PLL=0 .. FAULT=4)
`timescale 1ns/1ps

module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1000000,
    parameter int unsigned STABLE_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       retry,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFault     = 3'd4
    } state_e;

    localparam logic [23:0] RstLast     = 24'(RST_CYCLES - 1);
    localparam logic [23:0] TimeoutLast = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] StableLast  = 24'(STABLE_CYCLES - 1);
    localparam logic [2:0]  MaxTries    = 3'(MAX_RETRIES);

    state_e      state_q;
    logic        sync_q;
    logic        locked_s;
    logic [23:0] cnt;
    logic [2:0]  tries;

    assign state = state_q;

    // Outputs are updated together with the state so they change on the transition edge.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StResetPll;
            sync_q       <= 1'b0;
            locked_s     <= 1'b0;
            cnt          <= '0;
            tries        <= '0;
            pll_rst      <= 1'b1;
            core_reset   <= 1'b1;
            ready        <= 1'b0;
            fault        <= 1'b0;
            relock_count <= '0;
        end else begin
            sync_q   <= pll_locked;
            locked_s <= sync_q;
            unique case (state_q)
                StResetPll: begin
                    if (cnt == RstLast) begin
                        state_q <= StWaitLock;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                StWaitLock: begin
                    // Lock takes priority over a timeout in the same cycle.
                    if (locked_s) begin
                        state_q <= StStabilize;
                        cnt     <= '0;
                    end else if (cnt == TimeoutLast) begin
                        cnt <= '0;
                        if (tries == MaxTries) begin
                            state_q <= StFault;
                            fault   <= 1'b1;
                        end else begin
                            tries   <= tries + 3'd1;
                            state_q <= StResetPll;
                            pll_rst <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                StStabilize: begin
                    // A dropout restarts the lock window without charging a retry.
                    if (!locked_s) begin
                        state_q <= StWaitLock;
                        cnt     <= '0;
                    end else if (cnt == StableLast) begin
                        state_q    <= StRun;
                        cnt        <= '0;
                        tries      <= '0;
                        core_reset <= 1'b0;
                        ready      <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                StRun: begin
                    if (!locked_s) begin
                        state_q    <= StResetPll;
                        cnt        <= '0;
                        pll_rst    <= 1'b1;
                        core_reset <= 1'b1;
                        ready      <= 1'b0;
                        if (relock_count != 8'hFF) begin
                            relock_count <= relock_count + 8'd1;
                        end
                    end
                end
                StFault: begin
                    if (retry) begin
                        state_q <= StResetPll;
                        cnt     <= '0;
                        tries   <= '0;
                        pll_rst <= 1'b1;
                        fault   <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StResetPll;
                    cnt        <= '0;
                    tries      <= '0;
                    pll_rst    <= 1'b1;
                    core_reset <= 1'b1;
                    ready      <= 1'b0;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps

module tb_pll_lock_supervisor;

    localparam int unsigned RST     = 4;
    localparam int unsigned TIMEOUT = 32;
    localparam int unsigned STABLE  = 8;
    localparam int unsigned MAXR    = 2;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       retry = 1'b0;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [14:0] val;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor #(
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TIMEOUT),
        .STABLE_CYCLES(STABLE),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .retry       (retry),
        .pll_rst     (pll_rst),
        .core_reset  (core_reset),
        .ready       (ready),
        .fault       (fault),
        .relock_count(relock_count),
        .state       (state)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, state=%0d", state);
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] pk(input logic [2:0] s, input logic pr, input logic cr,
                                       input logic rd, input logic fl, input logic [7:0] rc);
        return {s, pr, cr, rd, fl, rc};
    endfunction

    function automatic logic [14:0] obs();
        return {state, pll_rst, core_reset, ready, fault, relock_count};
    endfunction

    function automatic void push(input string name, input logic [14:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with rst_n just released (edge count 0).
    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state === target) begin
                ok = 1'b1;
                return;
            end
            tick(1);
        end
        ok = (state === target);
    endtask

    task automatic test_reset();
        exp_t ex;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        push("reset_values", pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        tick(3);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
    endtask

    task automatic test_bringup();
        exp_t ex;
        push("bringup_rst_held", pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        push("bringup_rst_drop", pk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("bringup_wait", pk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("bringup_stab", pk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("bringup_pre_release", pk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("bringup_run", pk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        pll_locked = 1'b0;
        do_reset();
        tick(RST - 1);
        for (int k = 0; k < 2; k++) begin
            ex = sb.pop_front(); checks++;
            if (obs() !== ex.val) begin
                errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
            end
            if (k == 0) tick(1);
        end
        tick(10 - RST);
        pll_locked = 1'b1;
        tick(2);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(STABLE - 1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
    endtask

    task automatic test_glitch();
        exp_t ex;
        push("glitch_still_stab", pk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("glitch_back_to_wait", pk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("glitch_restab", pk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("glitch_no_early_release", pk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("glitch_run", pk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        pll_locked = 1'b0;
        do_reset();
        tick(RST);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        checks++;
        if (dut.tries !== 3'd0) begin
            errors++; $display("FAIL glitch_tries: got %0d, required 0", dut.tries);
        end
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(STABLE - 1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
    endtask

    // Starts in RUN with relock_count == 0.
    task automatic test_lock_loss();
        exp_t ex;
        push("loss_edge2_still_run", pk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        push("loss_edge3_reset", pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
        push("loss_rst_held", pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
        push("loss_rst_drop", pk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
        push("loss_relock_run", pk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1));
        pll_locked = 1'b0;
        tick(2);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(RST - 1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        pll_locked = 1'b1;
        tick(3 + STABLE);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
    endtask

    task automatic test_timeout();
        exp_t ex;
        int   per;
        per = RST + TIMEOUT;
        pll_locked = 1'b0;
        do_reset();
        for (int a = 1; a <= int'(MAXR) + 1; a++) begin
            push($sformatf("timeout%0d_waiting", a), pk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
            if (a <= int'(MAXR)) begin
                push($sformatf("timeout%0d_retry", a), pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
            end else begin
                push("timeout_fault", pk(3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
            end
            tick(per - 1);
            ex = sb.pop_front(); checks++;
            if (obs() !== ex.val) begin
                errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
            end
            tick(1);
            ex = sb.pop_front(); checks++;
            if (obs() !== ex.val) begin
                errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
            end
        end
        push("fault_latched", pk(3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
        push("fault_retry", pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        tick(5);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
    endtask

    task automatic test_saturation_retry();
        exp_t ex;
        bit   ok;
        int   exp_rc;
        pll_locked = 1'b1;
        do_reset();
        wait_state(3'd3, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL sat_first_run: state %0d, required 3", state);
        end
        exp_rc = 0;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            wait_state(3'd0, 20, ok);
            exp_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
            pll_locked = 1'b1;
            if (ok) wait_state(3'd3, 40, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL sat_loop%0d: state %0d, cycle budget expired", i, state);
                break;
            end
        end
        push("sat_count", pk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'(exp_rc)));
        push("retry_ignored", pk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'(exp_rc)));
        push("retry_ignored_later", pk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'(exp_rc)));
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(3);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
    endtask

    // Starts in RUN with relock_count saturated, so the async clear is visible.
    task automatic test_async_reset();
        exp_t ex;
        bit   ok;
        pll_locked = 1'b0;
        wait_state(3'd0, 20, ok);
        pll_locked = 1'b1;
        if (ok) wait_state(3'd2, 40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL async_reach_stab: state %0d, required 2", state);
        end
        push("async_reset_immediate", pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        push("async_restart_held", pk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        push("async_restart_wait", pk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("async_restart_stab", pk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        push("async_restart_run", pk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        #1;
        rst_n = 1'b1;
        tick(RST - 1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        // Lock is already synchronized, so WAIT_LOCK lasts a single cycle.
        tick(1);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
        tick(STABLE);
        ex = sb.pop_front(); checks++;
        if (obs() !== ex.val) begin
            errors++; $display("FAIL %s: got %h, required %h", ex.name, obs(), ex.val);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_glitch();
        test_lock_loss();
        test_timeout();
        test_saturation_retry();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
